// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types and defaults for the UART message arbiter slice.
// Revision: 1.0
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  localparam int CLK_FRE   = 50;      // MHz
  localparam int UART_RATE = 115200;  // baud

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_msg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_msg_arbiter_if
// Brief   : Source-side request bus plus uart_tx handshake of the arbiter.
// Revision: 1.0
// ============================================================================
interface uart_msg_arbiter_if
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
);
  localparam int IW = idx_width(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               send_en;
  logic [7:0]         send_data;
  logic               send_busy;
  logic [IW-1:0]      grant_id;
  logic               active;

  modport slave (
    input  req_valid, req_data, req_last, send_busy,
    output req_ready, send_en, send_data, grant_id, active
  );

  modport master (
    output req_valid, req_data, req_last, send_busy,
    input  req_ready, send_en, send_data, grant_id, active
  );

endinterface
`default_nettype wire

// File: rtl/uart_msg_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : First set request strictly after ptr, wrapping; purely combinational.
// Revision: 1.0
// ============================================================================
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  int            w_sum;
  logic [IW-1:0] w_cand;

  // Scan from farthest to nearest so the nearest hit is the last one written.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    w_sum  = 0;
    w_cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_sum  = (int'(ptr) + k) % N_REQ;
      w_cand = IW'(w_sum);
      if (req[w_cand]) begin
        valid = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_msg_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uart_msg_arbiter
// Brief   : Message-granular round-robin sharing of one uart_tx between sources.
// Revision: 1.0
// ============================================================================
module uart_msg_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int LOCK_TIMEOUT = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_msg_arbiter_if.slave  bus
);

  localparam int              IW        = idx_width(N_REQ);
  localparam int              CW        = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [IW-1:0]   c_ptr_rst = IW'(N_REQ - 1);
  localparam logic [CW-1:0]   c_timeout = CW'(LOCK_TIMEOUT);

  arb_state_t       r_state, w_state_nxt;
  logic [IW-1:0]    r_grant, w_grant_nxt;
  logic [IW-1:0]    r_ptr, w_ptr_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_send_en, w_send_en_nxt;
  logic [7:0]       r_send_data, w_send_data_nxt;
  logic             r_last, w_last_nxt;
  logic             r_active;
  logic [N_REQ-1:0] w_ready;

  logic             w_pick_valid;
  logic [IW-1:0]    w_pick_idx;
  logic             w_g_valid;
  logic             w_g_last;
  logic [7:0]       w_g_data;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req   (bus.req_valid),
    .ptr   (r_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  assign w_g_valid = bus.req_valid[r_grant];
  assign w_g_last  = bus.req_last[r_grant];
  assign w_g_data  = bus.req_data[int'(r_grant)*8 +: 8];

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_ptr_nxt       = r_ptr;
    w_cnt_nxt       = r_cnt;
    w_send_en_nxt   = 1'b0;
    w_send_data_nxt = r_send_data;
    w_last_nxt      = r_last;
    w_ready         = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_grant_nxt = w_pick_idx;
          w_cnt_nxt   = '0;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (w_g_valid) begin
          // A still-busy engine holds the byte back; the stall counter is not advanced.
          if (!bus.send_busy) begin
            w_ready[r_grant] = 1'b1;
            w_send_data_nxt  = w_g_data;
            w_send_en_nxt    = 1'b1;
            w_last_nxt       = w_g_last;
            w_cnt_nxt        = '0;
            w_state_nxt      = ACK;
          end
        end else if (r_cnt == c_timeout) begin
          w_ptr_nxt   = r_grant;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ACK: begin
        if (bus.send_busy) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (!bus.send_busy) begin
          if (r_last) begin
            w_ptr_nxt   = r_grant;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = XFER;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_ptr       <= c_ptr_rst;
      r_cnt       <= '0;
      r_send_en   <= 1'b0;
      r_send_data <= 8'h00;
      r_last      <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_send_en   <= w_send_en_nxt;
      r_send_data <= w_send_data_nxt;
      r_last      <= w_last_nxt;
      r_active    <= (w_state_nxt != IDLE);
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.send_en   = r_send_en;
  assign bus.send_data = r_send_data;
  assign bus.grant_id  = r_grant;
  assign bus.active    = r_active;

endmodule
`default_nettype wire
